lb_reg_responder: RTL and testbench

- Local-bus responder (slave) on the lb_* bus that the Ethernet/UDP bridge drives as initiator.
- Decodes lb_addr and holds the ID, scratch, control and status registers plus a saturating event counter.
- Returns lb_rdata at a fixed, parameterised read latency so the packet engine can place read data into the reply frame.
- Sits in the local-bus clock domain next to the bridge.

---
 rtl/lb_reg_responder.sv | 112 +++++++++++
 tb/tb_lb_reg_responder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/lb_reg_responder.sv
// lb_reg_responder: local-bus register slave with ID/scratch/ctrl/status/event registers
// and a fixed-latency, fully pipelined read path.
module lb_reg_responder #(
    parameter int          READ_LAT = 3,
    parameter int          NCTRL    = 8,
    parameter logic [31:0] ID_WORD  = 32'h4C4C5246
) (
    input  logic                  lb_clk,
    input  logic                  lb_rst_n,
    input  logic                  lb_valid,
    input  logic                  lb_rnw,
    input  logic [23:0]           lb_addr,
    input  logic [31:0]           lb_wdata,
    input  logic                  lb_renable,
    output logic [31:0]           lb_rdata,
    output logic [32*NCTRL-1:0]   ctrl_out,
    output logic [NCTRL-1:0]      ctrl_stb,
    input  logic [127:0]          status_in,
    input  logic                  evt_in
);

    logic             rd, wr;
    logic             is_id, is_scr, is_ctrl, is_stat, is_evt, is_bad, mapped;
    logic             bad_hit, bad_clr, evt_clr;
    logic [NCTRL-1:0] ctrl_sel;
    logic [31:0]      ctrl_rd, stat_word, rd_mux, scratch, evt_cnt;
    logic [15:0]      bad_cnt;
    logic             v_tail;
    logic [31:0]      d_tail;

    assign rd      = lb_valid & lb_rnw;
    assign wr      = lb_valid & ~lb_rnw;
    assign is_id   = lb_addr == 24'h000000;
    assign is_scr  = lb_addr == 24'h000001;
    assign is_stat = lb_addr[23:2] == 22'h000008;
    assign is_evt  = lb_addr == 24'h000030;
    assign is_bad  = lb_addr == 24'h000031;
    assign is_ctrl = |ctrl_sel;
    assign mapped  = is_id | is_scr | is_ctrl | is_stat | is_evt | is_bad;
    assign bad_hit = lb_valid & ~mapped;
    assign bad_clr = rd & is_bad & lb_renable;
    assign evt_clr = wr & is_evt;

    always_comb begin
        ctrl_sel = '0;
        ctrl_rd  = '0;
        for (int k = 0; k < NCTRL; k++)
            if (lb_addr == 24'(16 + k)) begin
                ctrl_sel[k] = 1'b1;
                ctrl_rd     = ctrl_out[32*k +: 32];
            end
    end

    assign stat_word = status_in[{lb_addr[1:0], 5'b0} +: 32];
    assign rd_mux = is_id   ? ID_WORD :
                    is_scr  ? scratch :
                    is_ctrl ? ctrl_rd :
                    is_stat ? stat_word :
                    is_evt  ? evt_cnt :
                    is_bad  ? {16'b0, bad_cnt} : 32'h0;

    // The last pipeline stage is lb_rdata itself, so READ_LAT-1 intermediate stages remain.
    generate
        if (READ_LAT == 1) begin : g_direct
            assign v_tail = rd;
            assign d_tail = rd_mux;
        end else begin : g_pipe
            logic        vq [READ_LAT-1];
            logic [31:0] dq [READ_LAT-1];
            always_ff @(posedge lb_clk or negedge lb_rst_n) begin
                if (!lb_rst_n) begin
                    for (int i = 0; i < READ_LAT - 1; i++) begin
                        vq[i] <= 1'b0;
                        dq[i] <= '0;
                    end
                end else begin
                    vq[0] <= rd;
                    dq[0] <= rd_mux;
                    for (int i = 1; i < READ_LAT - 1; i++) begin
                        vq[i] <= vq[i-1];
                        dq[i] <= dq[i-1];
                    end
                end
            end
            assign v_tail = vq[READ_LAT-2];
            assign d_tail = dq[READ_LAT-2];
        end
    endgenerate

    always_ff @(posedge lb_clk or negedge lb_rst_n) begin
        if (!lb_rst_n) begin
            scratch  <= '0;
            ctrl_out <= '0;
            ctrl_stb <= '0;
            evt_cnt  <= '0;
            bad_cnt  <= '0;
            lb_rdata <= '0;
        end else begin
            if (wr && is_scr) scratch <= lb_wdata;
            for (int k = 0; k < NCTRL; k++)
                if (wr && ctrl_sel[k]) ctrl_out[32*k +: 32] <= lb_wdata;
            ctrl_stb <= {NCTRL{wr}} & ctrl_sel;
            // A clear coinciding with a new event/bad access restarts at 1 so nothing is lost.
            evt_cnt  <= evt_clr ? {31'b0, evt_in} :
                        (evt_in && evt_cnt != '1) ? evt_cnt + 32'd1 : evt_cnt;
            bad_cnt  <= bad_clr ? {15'b0, bad_hit} :
                        (bad_hit && bad_cnt != '1) ? bad_cnt + 16'd1 : bad_cnt;
            if (v_tail) lb_rdata <= d_tail;
        end
    end

endmodule

// File: tb/tb_lb_reg_responder.sv
// tb_lb_reg_responder: directed self-checking bench for lb_reg_responder.
module tb_lb_reg_responder;

    localparam int          LAT = 3;
    localparam int          NC  = 8;
    localparam logic [31:0] ID  = 32'h4C4C5246;

    logic              lb_clk, lb_rst_n, lb_valid, lb_rnw, lb_renable, evt_in;
    logic [23:0]       lb_addr;
    logic [31:0]       lb_wdata, lb_rdata;
    logic [32*NC-1:0]  ctrl_out;
    logic [NC-1:0]     ctrl_stb;
    logic [127:0]      status_in;
    int                n_tests = 0;
    int                n_fail  = 0;
    logic [23:0]       pa [4];
    logic [31:0]       pe [4];

    lb_reg_responder #(.READ_LAT(LAT), .NCTRL(NC), .ID_WORD(ID)) dut (
        .lb_clk(lb_clk), .lb_rst_n(lb_rst_n), .lb_valid(lb_valid), .lb_rnw(lb_rnw),
        .lb_addr(lb_addr), .lb_wdata(lb_wdata), .lb_renable(lb_renable),
        .lb_rdata(lb_rdata), .ctrl_out(ctrl_out), .ctrl_stb(ctrl_stb),
        .status_in(status_in), .evt_in(evt_in)
    );

    initial lb_clk = 1'b0;
    always #5 lb_clk = ~lb_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected run to finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [23:0] a, input logic [31:0] d);
        lb_valid = 1'b1;
        lb_rnw   = 1'b0;
        lb_addr  = a;
        lb_wdata = d;
        @(negedge lb_clk);
        lb_valid = 1'b0;
    endtask

    task automatic bus_rd(input string tag, input logic [23:0] a, input logic ren,
                          input logic [31:0] exp);
        lb_valid   = 1'b1;
        lb_rnw     = 1'b1;
        lb_addr    = a;
        lb_renable = ren;
        @(negedge lb_clk);
        lb_valid   = 1'b0;
        lb_renable = 1'b0;
        repeat (LAT - 1) @(negedge lb_clk);
        check(tag, lb_rdata, exp);
    endtask

    initial begin
        lb_rst_n = 1'b0; lb_valid = 1'b0; lb_rnw = 1'b0; lb_addr = '0;
        lb_wdata = '0; lb_renable = 1'b0; status_in = '0; evt_in = 1'b0;
        repeat (3) @(negedge lb_clk);
        check("rst_rdata", lb_rdata, 32'h0);
        check("rst_ctrl", {31'b0, |ctrl_out}, 32'h0);
        check("rst_stb", {24'b0, ctrl_stb}, 32'h0);
        lb_rst_n = 1'b1;
        @(negedge lb_clk);

        // ID read latency: nothing before the third edge.
        lb_valid = 1'b1; lb_rnw = 1'b1; lb_addr = 24'h0;
        @(negedge lb_clk);
        lb_valid = 1'b0;
        check("lat_e1", lb_rdata, 32'h0);
        @(negedge lb_clk);
        check("lat_e2", lb_rdata, 32'h0);
        @(negedge lb_clk);
        check("lat_e3", lb_rdata, ID);

        // ctrl write, strobe, and read-after-write on the next cycle
        bus_wr(24'h12, 32'hA5A50001);
        lb_valid = 1'b1;
        check("stb_set", {24'b0, ctrl_stb}, 32'h4);
        check("ctrl2", ctrl_out[95:64], 32'hA5A50001);
        lb_rnw = 1'b1;
        @(negedge lb_clk);
        lb_valid = 1'b0;
        check("stb_clr", {24'b0, ctrl_stb}, 32'h0);
        repeat (LAT - 1) @(negedge lb_clk);
        check("raw", lb_rdata, 32'hA5A50001);
        bus_wr(24'h17, 32'h12345678);
        bus_rd("ctrl7", 24'h17, 1'b0, 32'h12345678);

        // back-to-back reads, one launch per cycle
        status_in = {32'd4, 32'd3, 32'd2, 32'd1};
        bus_wr(24'h1, 32'd7);
        pa = '{24'h20, 24'h21, 24'h01, 24'h500};
        pe = '{32'd1, 32'd2, 32'd7, 32'd0};
        for (int i = 0; i < 4 + LAT; i++) begin
            if (i >= LAT) check($sformatf("pipe%0d", i - LAT), lb_rdata, pe[i-LAT]);
            lb_valid = i < 4;
            lb_rnw   = 1'b1;
            if (i < 4) lb_addr = pa[i];
            @(negedge lb_clk);
        end
        lb_valid = 1'b0;
        bus_rd("bad_1", 24'h31, 1'b0, 32'd1);

        // RO write is ignored and not a bad access; write just past the ctrl range is bad
        bus_wr(24'h0, 32'hFFFFFFFF);
        bus_rd("id_ro", 24'h0, 1'b0, ID);
        bus_wr(24'h18, 32'hDEADBEEF);
        check("ctrl7_kept", ctrl_out[255:224], 32'h12345678);
        bus_rd("bad_peek", 24'h31, 1'b0, 32'd2);
        bus_rd("bad_clr", 24'h31, 1'b1, 32'd2);
        bus_rd("bad_zero", 24'h31, 1'b0, 32'd0);

        // event counter
        evt_in = 1'b1;
        repeat (5) @(negedge lb_clk);
        evt_in = 1'b0;
        bus_rd("evt5", 24'h30, 1'b0, 32'd5);
        evt_in = 1'b1;
        bus_wr(24'h30, 32'h0);
        evt_in = 1'b0;
        bus_rd("evt_clr_hit", 24'h30, 1'b0, 32'd1);
        bus_wr(24'h30, 32'h0);
        bus_rd("evt_clr", 24'h30, 1'b0, 32'd0);
        force dut.evt_cnt = 32'hFFFFFFFE;
        @(negedge lb_clk);
        release dut.evt_cnt;
        evt_in = 1'b1;
        repeat (3) @(negedge lb_clk);
        evt_in = 1'b0;
        bus_rd("evt_sat", 24'h30, 1'b0, 32'hFFFFFFFF);

        // reset while two reads are in flight
        lb_valid = 1'b1; lb_rnw = 1'b1; lb_addr = 24'h0;
        @(negedge lb_clk);
        lb_addr = 24'h12;
        @(negedge lb_clk);
        lb_valid = 1'b0;
        lb_rst_n = 1'b0;
        @(negedge lb_clk);
        lb_rst_n = 1'b1;
        check("mid_rst_ctrl", {31'b0, |ctrl_out}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("flush%0d", i), lb_rdata, 32'h0);
            @(negedge lb_clk);
        end
        bus_rd("evt_after_rst", 24'h30, 1'b0, 32'd0);
        bus_rd("id_after_rst", 24'h0, 1'b0, ID);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
